decrypt_rx: RTL and testbench
=============================

DECRYPT_RX -- requirements
Module: decrypt_rx

Interface
REQ-001 SHALL have ports in this order: clk, rst, then the remaining ports below.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 select  input  2  decrypt mode: 00 pass, 01 invert, 10 nibble swap, 11 invert + swap.
REQ-005 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-006 in_data  input  8  encrypted byte.
REQ-007 in_last  input  1  final byte of the current frame.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 out_valid  output  1  out_data/out_last hold a decrypted byte.
REQ-010 out_data  output  8  decrypted byte at the FIFO head.
REQ-011 out_last  output  1  last-of-frame flag travelling with out_data.
REQ-012 out_ready  input  1  downstream consumes the head byte this cycle.
REQ-013 busy  output  1  high while a frame is in progress (ACTIVE state).
REQ-014 frame_cnt  output  8  count of completed input frames.

Function
REQ-015 A byte is accepted on a rising edge where in_valid and in_ready are both high; it is consumed where out_valid and out_ready are both high.
REQ-016 Decrypt mapping (d = in_data): 00 -> d; 01 -> ~d; 10 -> {d[3:0],d[7:4]}; 11 -> ~{d[3:0],d[7:4]}.
REQ-017 Frame FSM has two states.
- IDLE: the first accepted byte is decrypted with the current select.
- IDLE: on that byte, select is latched into the mode register.
- IDLE: that byte moves the FSM to ACTIVE unless its in_last is high, in which case the FSM stays in IDLE.
REQ-018 ACTIVE: every accepted byte uses the latched mode, and select is ignored. An accepted byte with in_last=1 returns the FSM to IDLE.
REQ-019 busy SHALL equal (state == ACTIVE).
REQ-020 Buffering: a 4-entry FIFO stores {decrypted byte, in_last}.
REQ-021 Decryption occurs before the FIFO write; the FIFO holds plaintext.
REQ-022 in_ready SHALL be (count < 4) and SHALL NOT depend on out_ready in the same cycle.
REQ-023 out_valid SHALL be (count != 0). out_data and out_last SHALL show the head entry and SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 Latency: a byte accepted at edge N SHALL be visible at the outputs after edge N when the FIFO was empty. There is no combinational path from in_data to out_data.
REQ-025 Simultaneous accept and consume in one cycle: count is unchanged, and the pointers advance mod 4.
REQ-026 Consume with the FIFO empty SHALL have no effect.
REQ-027 Accept with the FIFO full is impossible because in_ready is low.
REQ-028 frame_cnt SHALL increment by 1 on every accepted byte with in_last=1, wrapping 255 -> 0.
REQ-029 frame_cnt counts input-side frames, independent of output draining.
REQ-030 in_valid while in_ready=0 SHALL be ignored and SHALL NOT alter state, mode or counters.

Reset
REQ-031 While rst=1 at a rising edge, the following SHALL all be cleared:
- state = IDLE and mode = 00;
- FIFO count = 0 and both pointers = 0;
- frame_cnt = 0.
REQ-032 After that edge: out_valid=0, out_data=00, out_last=0, busy=0, in_ready=1.
REQ-033 Reset mid-frame or with data buffered SHALL discard all buffered bytes and the partial frame. The next accepted byte is treated as a frame start.
REQ-034 Accept and consume are both blocked on any edge where rst=1.

Verification
REQ-035 Mode table:
- select=00, send 0x12 -> out 0x12.
- select=01, send 0x12 -> out 0xED.
- select=10, send 0x12 -> out 0x21.
- select=11, send 0x12 -> out 0xDE.
- Each byte is sent as a single-byte frame with out_ready=1, and out_valid is high one cycle after acceptance.
REQ-036 Mode lock:
- Start a frame with select=10 and send 0xA5 -> 0x5A.
- Switch select to 01 mid-frame and send 0x3C, 0x0F (last) -> 0xC3, 0xF0.
- Next frame with select=01 and send 0x0F -> 0xF0.
REQ-037 Backpressure:
- Hold out_ready=0 and offer 5 bytes 0x01..0x05 with select=00.
- in_ready drops after the 4th acceptance, and 0x05 stays pending.
- Raise out_ready: outputs appear in order 0x01..0x05, with no loss or duplication.
REQ-038 Full-rate streaming: out_ready=1, in_valid=1 continuously for 20 bytes. Throughput is 1 byte/cycle, count never exceeds 1, and out_last aligns with the in_last byte.
REQ-039 Reset mid-frame:
- With 3 bytes buffered and busy=1, assert rst for one cycle.
- Next cycle: out_valid=0, busy=0, frame_cnt=0.
- A new byte then uses the current select.
REQ-040 Counter wrap: send 256 single-byte frames -> frame_cnt returns to 0x00. After 255 frames it reads 0xFF.

Source files
------------

// File: rtl/decrypt_rx.sv
// decrypt_rx: frame-aware byte decryptor feeding a 4-entry plaintext FIFO.
//
// state  | meaning
// IDLE   | no frame open; next accepted byte starts a frame using live select
// ACTIVE | frame open; bytes use the mode latched at frame start
module decrypt_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] select,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  eff_mode;
  logic [7:0]  plain;

  logic [8:0]  fifo_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        accept;
  logic        consume;
  logic [8:0]  head;

  // Handshakes; in_ready depends only on the registered fill level.
  assign in_ready  = (count_q < 3'd4);
  assign out_valid = (count_q != 3'd0);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  assign head      = fifo_q[rd_ptr_q];
  assign out_data  = out_valid ? head[8:1] : 8'h00;
  assign out_last  = out_valid ? head[0]   : 1'b0;
  assign busy      = (state_q == ACTIVE);
  assign frame_cnt = frame_cnt_q;

  // Frame FSM next state and mode latch; a frame's first byte uses live select.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    eff_mode = (state_q == IDLE) ? select : mode_q;
    if (accept) begin
      if (state_q == IDLE) begin
        mode_d = select;
      end
      state_d = in_last ? IDLE : ACTIVE;
    end
  end

  // Byte mapping applied before the FIFO write.
  always_comb begin
    plain = in_data;
    case (eff_mode)
      2'b00:   plain = in_data;
      2'b01:   plain = ~in_data;
      2'b10:   plain = {in_data[3:0], in_data[7:4]};
      default: plain = ~{in_data[3:0], in_data[7:4]};
    endcase
  end

  // FIFO pointer, fill level and frame counter next-state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (consume) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({accept, consume})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (accept && in_last) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Control registers with synchronous reset; reset blocks accept and consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 2'b00;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      fifo_q[wr_ptr_q] <= {plain, in_last};
    end
  end

endmodule

// File: tb/tb_decrypt_rx.sv
// Self-checking bench for decrypt_rx: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_decrypt_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] select;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  decrypt_rx dut (
    .clk       (clk),
    .rst       (rst),
    .select    (select),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference mapping from arithmetic: swap = lo*16+hi, invert = 255-x.
  function automatic logic [7:0] dec(input int d, input int m);
    int r;
    r = d;
    if (m == 2 || m == 3) r = (d % 16) * 16 + d / 16;
    if (m == 1 || m == 3) r = 255 - r;
    return 8'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    select = 2'b11; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; select = 2'b00;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (frame_cnt !== 8'h00) begin errors++; $display("FAIL reset_frame_cnt got %h want 00", frame_cnt); end
  endtask

  task automatic test_modes();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'h12; exp_tab[1] = 8'hED; exp_tab[2] = 8'h21; exp_tab[3] = 8'hDE;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s); in_data = 8'h12; in_valid = 1'b1; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got %b want 1", s, out_valid); end
      checks++; if (out_data !== exp_tab[s]) begin errors++; $display("FAIL mode%0d_data got %h want %h", s, out_data, exp_tab[s]); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL mode%0d_last got %b want 1", s, out_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode%0d_busy got %b want 0", s, busy); end
      tick();
    end
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL modes_frame_cnt got %0d want 4", frame_cnt); end
  endtask

  task automatic test_mode_lock();
    out_ready = 1'b1;
    select = 2'b10; in_data = 8'hA5; in_last = 1'b0; in_valid = 1'b1;
    tick();
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL lock_first got %h want 5a", out_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy got %b want 1", busy); end
    select = 2'b01; in_data = 8'h3C;
    tick();
    checks++; if (out_data !== 8'hC3) begin errors++; $display("FAIL lock_second got %h want c3", out_data); end
    in_data = 8'h0F; in_last = 1'b1;
    tick();
    checks++; if (out_data !== 8'hF0) begin errors++; $display("FAIL lock_third got %h want f0", out_data); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL lock_third_last got %b want 1", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_end_busy got %b want 0", busy); end
    in_data = 8'h0F; in_last = 1'b1;
    tick();
    checks++; if (out_data !== 8'hF0) begin errors++; $display("FAIL lock_next_frame got %h want f0", out_data); end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int got;
    bit acc;
    out_ready = 1'b0; select = 2'b00; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d got %b want 1", i, in_ready); end
      tick();
    end
    in_data = 8'h05; in_last = 1'b1; select = 2'b11;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got %b want 0", in_ready); end
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL bp_hold_head got %h want 01", out_data); end
    checks++; if (frame_cnt !== 8'd6) begin errors++; $display("FAIL bp_blocked_frame_cnt got %0d want 6", frame_cnt); end
    out_ready = 1'b1; got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      if (out_valid) begin
        checks++; if (out_data !== 8'(got + 1)) begin errors++; $display("FAIL bp_order_%0d got %h want %h", got, out_data, 8'(got + 1)); end
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin in_valid = 1'b0; in_last = 1'b0; end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL bp_drain_count got %0d want 5", got); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 8'd7) begin errors++; $display("FAIL bp_frame_cnt got %0d want 7", frame_cnt); end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_streaming();
    int m;
    bit start;
    logic [7:0] exp;
    logic       exp_last;
    out_ready = 1'b1; in_valid = 1'b1; start = 1'b1; m = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 5 || i == 10 || i == 13) select = 2'($urandom_range(0, 3));
      in_data  = 8'($urandom);
      exp_last = (i == 9 || i == 19);
      in_last  = exp_last;
      if (start) m = int'(select);
      exp   = dec(int'(in_data), m);
      start = exp_last;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp || out_last !== exp_last)
        begin errors++; $display("FAIL stream_byte_%0d got v%b %h l%b want v1 %h l%b", i, out_valid, out_data, out_last, exp, exp_last); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 8'd9) begin errors++; $display("FAIL stream_frame_cnt got %0d want 9", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0; select = 2'b01; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
    end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got busy %b valid %b want 1 1", busy, out_valid); end
    rst = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (frame_cnt !== 8'h00) begin errors++; $display("FAIL rmid_frame_cnt got %h want 00", frame_cnt); end
    select = 2'b10; in_data = 8'h12; in_valid = 1'b1; in_last = 1'b0;
    tick();
    checks++; if (out_data !== 8'h21 || busy !== 1'b1) begin errors++; $display("FAIL rmid_new_frame got %h busy %b want 21 1", out_data, busy); end
    select = 2'b00; in_data = 8'h34; in_last = 1'b1;
    tick();
    checks++; if (out_data !== 8'h43 || out_last !== 1'b1) begin errors++; $display("FAIL rmid_locked got %h l%b want 43 l1", out_data, out_last); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rmid_frame_cnt_after got %0d want 1", frame_cnt); end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1; select = 2'b00;
    for (int i = 0; i < 255; i++) begin
      in_data = 8'(i);
      tick();
    end
    checks++; if (frame_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_255 got %h want ff", frame_cnt); end
    tick();
    checks++; if (frame_cnt !== 8'h00) begin errors++; $display("FAIL wrap_256 got %h want 00", frame_cnt); end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int  q_data[$];
    bit  q_last[$];
    bit  m_active;
    int  m_mode;
    int  m_frames;
    bit  acc, cons;
    int  use_mode;
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_active = 1'b0; m_mode = 0; m_frames = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      select    = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      checks++; if (in_ready !== (q_data.size() < 4)) begin errors++; $display("FAIL rnd_ready_%0d got %b want %b", cyc, in_ready, q_data.size() < 4); end
      checks++; if (out_valid !== (q_data.size() != 0)) begin errors++; $display("FAIL rnd_valid_%0d got %b want %b", cyc, out_valid, q_data.size() != 0); end
      checks++; if (busy !== m_active) begin errors++; $display("FAIL rnd_busy_%0d got %b want %b", cyc, busy, m_active); end
      checks++; if (frame_cnt !== 8'(m_frames)) begin errors++; $display("FAIL rnd_frames_%0d got %0d want %0d", cyc, frame_cnt, m_frames % 256); end
      if (q_data.size() != 0) begin
        checks++; if (out_data !== 8'(q_data[0]) || out_last !== q_last[0])
          begin errors++; $display("FAIL rnd_head_%0d got %h l%b want %h l%b", cyc, out_data, out_last, 8'(q_data[0]), q_last[0]); end
      end
      acc  = in_valid && (q_data.size() < 4);
      cons = out_ready && (q_data.size() != 0);
      tick();
      if (cons) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      if (acc) begin
        use_mode = m_active ? m_mode : int'(select);
        if (!m_active) m_mode = int'(select);
        q_data.push_back(int'(dec(int'(in_data), use_mode)));
        q_last.push_back(in_last);
        if (in_last) begin
          m_active = 1'b0;
          m_frames++;
        end else begin
          m_active = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; select = 2'b00; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_modes();
    test_mode_lock();
    test_backpressure();
    test_streaming();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
